zbus_arbiter: RTL and testbench

- N-to-1 zbus arbiter that merges BN requesting zbus masters onto one shared zbus output.
- Sits directly upstream of zbus_demux. Its registered one-hot grant drives the demux enable lines, so the return path is routed back to the current owner.
- Round-robin fairness, with per-master lock for multi-transfer bursts.
- Transfer rule on every port: a transfer occurs in a cycle where vld and ack are both high. A master holds vld and bus stable until it sees ack.

---
 rtl/zbus_arb_rr.sv | 39 +++
 rtl/zbus_arbiter.sv | 101 ++++++++++
 tb/tb_zbus_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/zbus_arb_rr.sv
// ============================================================================
// Module   : zbus_arb_rr
// Purpose  : Rotating-priority picker, scanning from ptr+1 upward with wrap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zbus_arb_rr #(
  parameter int BN = 4,
  parameter int PW = (BN > 1) ? $clog2(BN) : 1
) (
  input  logic [BN-1:0] req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [BN-1:0] gnt_o,
  output logic [PW-1:0] index_o,
  output logic          any_o
);

  always_comb begin : p_pick
    int   j;
    logic found;
    gnt_o   = '0;
    index_o = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= BN; k++) begin
      j = (int'(ptr_i) + k) % BN;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        index_o  = PW'(j);
      end
    end
    any_o = found;
  end

endmodule

`default_nettype wire

// File: rtl/zbus_arbiter.sv
// ============================================================================
// Module   : zbus_arbiter
// Purpose  : Round-robin N-to-1 zbus arbiter with per-master burst lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zbus_arbiter #(
  parameter int   BW = 8,
  parameter int   BN = 4,
  parameter logic DI = 1'bx
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BN-1:0]    zi_vld,
  input  logic [BW*BN-1:0] zi_bus,
  output logic [BN-1:0]    zi_ack,
  output logic             zo_vld,
  output logic [BW-1:0]    zo_bus,
  input  logic             zo_ack,
  input  logic [BN-1:0]    lock,
  output logic [BN-1:0]    grant
);

  localparam int PW = (BN > 1) ? $clog2(BN) : 1;

  logic [BN-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic [PW-1:0] w_g_idx;
  logic [PW-1:0] w_pick_ptr;
  logic [BN-1:0] w_pick_gnt;
  logic [PW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic          w_idle;
  logic          w_lock_g;
  logic          w_vld_g;
  logic          w_xfer;
  logic          w_release;

  always_comb begin : p_gidx
    w_g_idx = '0;
    for (int i = 0; i < BN; i++) begin
      if (gnt_q[i]) w_g_idx = PW'(i);
    end
  end

  always_comb begin : p_bus_mux
    zo_bus = {BW{DI}};
    for (int i = 0; i < BN; i++) begin
      if (gnt_q[i]) zo_bus = zi_bus[i*BW +: BW];
    end
  end

  assign grant  = gnt_q;
  assign zo_vld = |(gnt_q & zi_vld);
  assign zi_ack = gnt_q & {BN{zo_ack}};

  assign w_idle   = (gnt_q == '0);
  assign w_lock_g = |(gnt_q & lock);
  assign w_vld_g  = |(gnt_q & zi_vld);
  assign w_xfer   = zo_vld & zo_ack;

  // An unlocked owner gives up the bus once it transfers or stops requesting;
  // an idle arbiter is treated as a release so one picker covers both cases.
  assign w_release  = w_idle | (~w_lock_g & (w_xfer | ~w_vld_g));
  assign w_pick_ptr = w_idle ? ptr_q : w_g_idx;

  zbus_arb_rr #(
    .BN (BN),
    .PW (PW)
  ) u_rr (
    .req_i   (zi_vld & ~gnt_q),
    .ptr_i   (w_pick_ptr),
    .gnt_o   (w_pick_gnt),
    .index_o (w_pick_idx),
    .any_o   (w_pick_any)
  );

  always_comb begin : p_next
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (w_release) begin
      gnt_d = w_pick_gnt;
      if (w_pick_any) ptr_d = w_pick_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= '0;
      ptr_q <= PW'(BN - 1);
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zbus_arbiter.sv
// ============================================================================
// Module   : tb_zbus_arbiter
// Purpose  : Randomized scoreboard bench for zbus_arbiter against an owner model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_zbus_arbiter;

  localparam int BW = 8;
  localparam int BN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [BN-1:0]    zi_vld;
  logic [BW*BN-1:0] zi_bus;
  logic [BN-1:0]    zi_ack;
  logic             zo_vld;
  logic [BW-1:0]    zo_bus;
  logic             zo_ack;
  logic [BN-1:0]    lock;
  logic [BN-1:0]    grant;

  always #5 clk = ~clk;

  zbus_arbiter #(
    .BW (BW),
    .BN (BN),
    .DI (1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .zi_vld (zi_vld),
    .zi_bus (zi_bus),
    .zi_ack (zi_ack),
    .zo_vld (zo_vld),
    .zo_bus (zo_bus),
    .zo_ack (zo_ack),
    .lock   (lock),
    .grant  (grant)
  );

  typedef struct packed {
    logic [BN-1:0] grant;
    logic          vld;
    logic [BW-1:0] bus;
    logic [BN-1:0] ack;
  } exp_t;

  typedef struct packed {
    logic [BN-1:0] who;
    logic [BW-1:0] data;
  } xf_t;

  exp_t exp_q[$];
  xf_t  xf_q[$];

  // Model state: current bus owner (-1 when idle) and the last master granted.
  int            owner;
  int            last;
  logic [BN-1:0] done_m;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [BN-1:0] req, input int base);
    for (int k = 1; k <= BN; k++) begin
      int j = (base + k) % BN;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // Advance the model across one clock edge using the inputs held this cycle.
  task automatic model_step();
    done_m = '0;
    if (owner >= 0 && zo_ack && zi_vld[owner]) done_m[owner] = 1'b1;
    if (rst) begin
      owner = -1;
      last  = BN - 1;
    end else if (owner < 0) begin
      owner = rr_pick(zi_vld, last);
      if (owner >= 0) last = owner;
    end else begin
      bit            xf;
      bit            keep;
      logic [BN-1:0] others;
      int            nxt;
      xf     = zi_vld[owner] && zo_ack;
      keep   = lock[owner] || (zi_vld[owner] && !xf);
      others = zi_vld;
      others[owner] = 1'b0;
      if (!keep) begin
        nxt = rr_pick(others, owner);
        if (nxt >= 0) last = nxt;
        owner = nxt;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.grant = '0;
    if (owner >= 0) e.grant[owner] = 1'b1;
    e.vld = (owner >= 0) && zi_vld[owner];
    e.bus = (owner >= 0) ? zi_bus[owner*BW +: BW] : {BW{1'b0}};
    e.ack = zo_ack ? e.grant : '0;
    exp_q.push_back(e);
    if (e.vld && zo_ack) xf_q.push_back('{who: e.grant, data: e.bus});
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < BN; i++) begin
      if (done_m[i] || !zi_vld[i]) begin
        zi_vld[i]           = ($urandom_range(0, 2) == 0);
        zi_bus[i*BW +: BW]  = BW'($urandom);
      end
      lock[i] = ($urandom_range(0, 2) == 0);
    end
    zo_ack = ($urandom_range(0, 3) != 0);
    rst    = ($urandom_range(0, 79) == 0);
  endtask

  always @(negedge clk) begin : p_monitor
    exp_t e;
    xf_t  x;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant",  32'(grant),  32'(e.grant));
      chk("zo_vld", 32'(zo_vld), 32'(e.vld));
      chk("zo_bus", 32'(zo_bus), 32'(e.bus));
      chk("zi_ack", 32'(zi_ack), 32'(e.ack));
      if (zo_vld && zo_ack) begin
        if (xf_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL xfer: got unexpected transfer grant=%0h bus=%0h, expected none", grant, zo_bus);
        end else begin
          x = xf_q.pop_front();
          chk("xfer", {20'd0, grant, zo_bus}, {20'd0, x.who, x.data});
        end
      end
    end
  end

  initial begin
    owner  = -1;
    last   = BN - 1;
    done_m = '0;
    rst    = 1'b1;
    zi_vld = '1;
    lock   = '0;
    zo_ack = 1'b1;
    zi_bus = {$urandom, $urandom};

    // Two reset cycles with every master requesting.
    @(posedge clk); model_step(); #1;
    push_exp();
    @(posedge clk); model_step(); #1;
    chk("reset_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    push_exp();

    // All masters streaming with ack high and no lock: strict rotation.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); model_step(); #1;
      for (int i = 0; i < BN; i++) begin
        if (done_m[i]) zi_bus[i*BW +: BW] = BW'($urandom);
      end
      push_exp();
    end

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); model_step(); #1;
      rand_inputs();
      push_exp();
    end

    @(negedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("xf_q_drained",  32'(xf_q.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
